// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction memory and
// feeds decode through a small skid FIFO. Optional jump predecode: FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
    parameter int PC_W      = 16,
    parameter int INSTR_W   = 24,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    localparam int AW = $clog2(BUF_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_epoch;
    logic               r_inflight;
    logic               r_inflight_epoch;
    logic [PC_W-1:0]    r_inflight_pc;
    logic [INSTR_W-1:0] r_fifo_data [BUF_DEPTH];
    logic [PC_W-1:0]    r_fifo_pc   [BUF_DEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW:0]        r_count;

    logic               w_empty;
    logic               w_valid;
    logic               w_consume;
    logic               w_halt;
    logic               w_redirect;
    logic               w_resp_ok;
    logic               w_enq;
    logic               w_jump;
    logic               w_req;
    logic [AW+1:0]      w_level;
    logic [INSTR_W-1:0] w_head_data;
    logic [PC_W-1:0]    w_head_pc;

    assign w_empty     = (r_count == '0);
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_pc   = r_fifo_pc[r_rd_ptr];
    assign w_valid     = (r_state != ST_HALT) && !w_empty;
    assign w_consume   = w_valid && !stall;

    // Halt outranks a same-edge redirect: the zero word is consumed first, then fetch stops.
    assign w_halt      = w_consume && (w_head_data == '0);
    assign w_redirect  = (r_state == ST_RUN) && redirect && !w_halt;

    assign w_resp_ok   = r_inflight && (r_inflight_epoch == r_epoch) && (r_state != ST_HALT);
    assign w_enq       = w_resp_ok && !w_halt && !w_redirect;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign w_jump = w_enq && (r_state == ST_RUN) && (imem_rdata[INSTR_W-1 -: 4] == 4'b0100);
`else
    assign w_jump = 1'b0;
`endif

    // Outstanding work after this edge must fit the FIFO, counting a word that leaves now.
    assign w_level = (AW+2)'(r_count) + (AW+2)'(r_inflight) - (AW+2)'(w_consume);
    assign w_req   = rst_n && (r_state == ST_RUN) && (w_level < (AW+2)'(BUF_DEPTH));

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? w_head_data : '0;
    assign instr_pc    = w_valid ? w_head_pc : '0;
    assign halted      = (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_pc             <= '0;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= '0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
        end else begin
            r_inflight       <= w_req;
            r_inflight_epoch <= r_epoch;
            r_inflight_pc    <= r_pc;

            if (w_redirect) begin
                r_pc <= redirect_pc;
            end else if (w_jump) begin
                r_pc <= imem_rdata[PC_W-1:0];
            end else if (w_req) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_redirect || w_jump) begin
                r_epoch <= ~r_epoch;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_halt) begin
                        r_state <= ST_HALT;
                    end else if (w_redirect || w_jump) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: r_state <= w_halt ? ST_HALT : ST_RUN;
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_RUN;
            endcase

            if (w_halt || w_redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_consume) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_consume);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, scoreboard of expected (pc, instr)
// pairs popped whenever decode consumes a word.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [23:0] imem_rdata;
    logic [23:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q [$];
    logic [23:0] mem [0:65535];

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic [15:0] PC_AFTER_JUMP = 16'h0030;
`else
    localparam logic [15:0] PC_AFTER_JUMP = 16'h0003;
`endif

    fetch_unit #(.PC_W(16), .INSTR_W(24), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL consume_unexpected obs pc=%h instr=%h exp none", instr_pc, instr);
            end
            if (exp_q.size() != 0) begin
                logic [39:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({instr_pc, instr} === e) else begin
                    errors++;
                    $error("FAIL consume obs pc=%h instr=%h exp pc=%h instr=%h",
                           instr_pc, instr, e[39:24], e[23:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc);
        exp_q.push_back({pc, mem[pc]});
    endtask

    task automatic wait_head(input logic [15:0] pc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == pc) seen = 1'b1;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s head pc %h obs=0 exp=1", tag, pc);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rdata  = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 24'h100000 + 24'(a);
        mem[2] = 24'h400030;
        mem[5] = 24'h000000;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        push(16'h0000); push(16'h0001); push(16'h0002); push(PC_AFTER_JUMP);
        rst_n = 1'b1;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", 32'(imem_addr), 32'd0);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", 32'(imem_addr), 32'd1);
        @(negedge clk);
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc", 32'(instr_pc), 32'd0);

        // Hold decode for three cycles on the second word.
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr", 32'(instr), 32'h100001);
            chk("stall_pc", 32'(instr_pc), 32'd1);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;

        wait_head(PC_AFTER_JUMP, "seq_end");
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        push(16'h0040); push(16'h0041);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", 32'(imem_addr), 32'h0040);

        wait_head(16'h0041, "redir_seq");
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        push(16'hFFFF); push(16'h0000);
        @(posedge clk); #1;
        redirect = 1'b0;

        wait_head(16'h0000, "wrap");
        redirect    = 1'b1;
        redirect_pc = 16'h0004;
        push(16'h0004); push(16'h0005);
        @(posedge clk); #1;
        redirect = 1'b0;

        wait_head(16'h0005, "halt_word");
        chk("halt_word_instr", 32'(instr), 32'd0);
        @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                redirect    = 1'b1;
                redirect_pc = 16'h0010;
            end
            if (i == 6) redirect = 1'b0;
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'd0);
        end
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_sticky_valid", 32'(instr_valid), 32'd0);

        // Reset in HALT restarts fetch from address 0.
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_req", 32'(imem_req), 32'd0);
        chk("rst2_addr", 32'(imem_addr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        push(16'h0000);
        rst_n = 1'b1;
        wait_head(16'h0000, "rst2_first");
        @(posedge clk); #1;
        stall = 1'b1;
        @(negedge clk);
        chk("rst2_hold_pc", 32'(instr_pc), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
